// File: rtl/rv32i_types.sv
// +--------------------------------------------------------------------+
// | rv32i_types : shared types for the RV32I pipeline control slice    |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

package rv32i_types;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DMEM_WAIT  = 2'd1,
    FLUSH_PEND = 2'd2
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic load;
    logic flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t STG_LOAD  = '{load: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t STG_HOLD  = '{load: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t STG_FLUSH = '{load: 1'b0, flush: 1'b1};

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// +--------------------------------------------------------------------+
// | hazard_detect : load-use compare between EX destination and ID    |
// |                 sources (x0 never creates a dependency)            |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

module hazard_detect (
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       luse_o
);

  assign luse_o = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                  ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// +--------------------------------------------------------------------+
// | pipeline_ctrl : hazard/stall sequencer for the 5-stage RV32I pipe  |
// |                 Optional perf counters with PIPE_PERF_CTR_EN.      |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

module pipeline_ctrl
  import rv32i_types::*;
`ifdef PIPE_PERF_CTR_EN
#(
  parameter int CTR_W = 32
)
`endif
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             imem_stall_i,
  input  logic             dmem_req_i,
  input  logic             dmem_resp_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             br_taken_i,
  output logic             pc_load_o,
  output logic             if_id_load_o,
  output logic             if_id_flush_o,
  output logic             id_ex_load_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_load_o,
  output logic             ex_mem_flush_o,
  output logic             mem_wb_load_o,
`ifdef PIPE_PERF_CTR_EN
  output logic             mem_wb_flush_o,
  output logic [CTR_W-1:0] stall_cnt_o,
  output logic [CTR_W-1:0] flush_cnt_o
`else
  output logic             mem_wb_flush_o
`endif
);

  pipe_ctrl_state_t state_q, state_d;
  stage_ctrl_t      if_id, id_ex, ex_mem, mem_wb;
  logic             pc_load;
  logic             redirect;
  logic             luse;
  logic             dstall;

  hazard_detect u_hazard_detect (
    .ex_mem_read_i (ex_mem_read_i),
    .ex_rd_i       (ex_rd_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .luse_o        (luse)
  );

  assign dstall = dmem_req_i & ~dmem_resp_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pc_load  = 1'b1;
    if_id    = STG_LOAD;
    id_ex    = STG_LOAD;
    ex_mem   = STG_LOAD;
    mem_wb   = STG_LOAD;
    redirect = 1'b0;

    if (dstall) begin
      pc_load = 1'b0;
      if_id   = STG_HOLD;
      id_ex   = STG_HOLD;
      ex_mem  = STG_HOLD;
      mem_wb  = STG_FLUSH;
      if (state_q != FLUSH_PEND) state_d = DMEM_WAIT;
    end else if (state_q == FLUSH_PEND) begin
      // Wrong-path fetch still in flight: keep PC and squash whatever IF delivers.
      pc_load = 1'b0;
      if_id   = STG_FLUSH;
      if (!imem_stall_i) state_d = RUN;
    end else begin
      state_d = RUN;
      if (br_taken_i) begin
        redirect = 1'b1;
        if_id    = STG_FLUSH;
        id_ex    = STG_FLUSH;
        if (imem_stall_i) state_d = FLUSH_PEND;
      end else if (luse) begin
        pc_load = 1'b0;
        if_id   = STG_HOLD;
        id_ex   = STG_FLUSH;
      end else if (imem_stall_i) begin
        pc_load = 1'b0;
        if_id   = STG_FLUSH;
      end
    end

    if (rst_i) begin
      pc_load  = 1'b0;
      if_id    = STG_HOLD;
      id_ex    = STG_HOLD;
      ex_mem   = STG_HOLD;
      mem_wb   = STG_HOLD;
      redirect = 1'b0;
    end
  end

  assign pc_load_o      = pc_load;
  assign if_id_load_o   = if_id.load;
  assign if_id_flush_o  = if_id.flush;
  assign id_ex_load_o   = id_ex.load;
  assign id_ex_flush_o  = id_ex.flush;
  assign ex_mem_load_o  = ex_mem.load;
  assign ex_mem_flush_o = ex_mem.flush;
  assign mem_wb_load_o  = mem_wb.load;
  assign mem_wb_flush_o = mem_wb.flush;

`ifdef PIPE_PERF_CTR_EN
  logic [CTR_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_load) stall_cnt_q <= stall_cnt_q + CTR_W'(1);
      if (redirect) flush_cnt_q <= flush_cnt_q + CTR_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

`default_nettype wire
